// File: rtl/control_pipe_pkg.sv
// Shared opcode, function and selector encodings for the ID-stage control unit,
// plus the control-word layout carried from decode to the output register.
package control_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_SLL  = 6'b000010;
  localparam logic [5:0] ALU_SRL  = 6'b000100;
  localparam logic [5:0] ALU_SRA  = 6'b000110;
  localparam logic [5:0] ALU_OR   = 6'b001000;
  localparam logic [5:0] ALU_AND  = 6'b010000;
  localparam logic [5:0] ALU_XOR  = 6'b100000;
  localparam logic [5:0] ALU_SLT  = 6'b101001;
  localparam logic [5:0] ALU_SLTU = 6'b110001;

  localparam logic [1:0] PC_4    = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_JAL  = 2'b11;

  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_IIMM = 2'b01;
  localparam logic [1:0] OP2_UIMM = 2'b10;
  localparam logic [1:0] OP2_SIMM = 2'b11;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MD  = 2'b11;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic [1:0] op1sel;
    logic [1:0] op2sel;
    logic [1:0] wb_sel;
    logic       mem_wr;
    logic       mem_rd;
    logic [2:0] mem_size;
    logic       rf_en;
    logic       md_op;
    logic [5:0] alu_fun;
    logic       illegal;
  } ctl_word_t;

  localparam int unsigned CTL_W = $bits(ctl_word_t);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_t;

  // alt selects SUB/SRA (instr[30]) within the shared funct3 map
  function automatic logic [5:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_pipe_decode.sv
// Combinational RV32I(+M) decoder: raw instruction to control word.
// Any unrecognised encoding yields an all-zero word with only the illegal flag set.
module control_decode
  import control_pipe_pkg::*;
#(
  parameter int unsigned EN_M = 1
) (
  input  logic [31:0]      instr,
  output logic [CTL_W-1:0] ctl,
  output logic             md_is_div
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  ctl_word_t  w;
  logic       legal;

  assign opc       = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign md_is_div = f3[2];

  always_comb begin
    w     = '0;
    legal = 1'b1;
    case (opc)
      OPC_OP: begin
        w.op2sel = OP2_RS2;
        w.wb_sel = WB_ALU;
        w.rf_en  = 1'b1;
        if (f7 == F7_MULDIV) begin
          if (EN_M != 0) begin
            w.md_op   = 1'b1;
            w.wb_sel  = WB_MD;
            w.alu_fun = {3'b000, f3};
          end else begin
            legal = 1'b0;
          end
        end else if (f7 == F7_BASE) begin
          w.alu_fun = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          w.alu_fun = alu_from_f3(f3, 1'b1);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        w.op2sel = OP2_IIMM;
        w.wb_sel = WB_ALU;
        w.rf_en  = 1'b1;
        if (f3 == 3'b001) begin
          legal     = (f7 == F7_BASE);
          w.alu_fun = ALU_SLL;
        end else if (f3 == 3'b101) begin
          legal     = (f7 == F7_BASE) || (f7 == F7_ALT);
          w.alu_fun = alu_from_f3(f3, instr[30]);
        end else begin
          w.alu_fun = alu_from_f3(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        w.op2sel   = OP2_IIMM;
        w.wb_sel   = WB_MEM;
        w.mem_rd   = 1'b1;
        w.rf_en    = 1'b1;
        w.mem_size = f3;
        legal      = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        w.op2sel   = OP2_SIMM;
        w.mem_wr   = 1'b1;
        w.mem_size = f3;
        legal      = f3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_BRANCH: begin
        w.pc_sel  = PC_BR;
        w.alu_fun = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        legal     = (f3[2:1] != 2'b01);
      end
      OPC_JAL: begin
        w.pc_sel = PC_JAL;
        w.wb_sel = WB_PC4;
        w.rf_en  = 1'b1;
      end
      OPC_JALR: begin
        w.pc_sel = PC_JALR;
        w.op2sel = OP2_IIMM;
        w.wb_sel = WB_PC4;
        w.rf_en  = 1'b1;
        legal    = (f3 == 3'b000);
      end
      OPC_LUI: begin
        w.op1sel = OP1_ZERO;
        w.op2sel = OP2_UIMM;
        w.wb_sel = WB_ALU;
        w.rf_en  = 1'b1;
      end
      OPC_AUIPC: begin
        w.op1sel = OP1_PC;
        w.op2sel = OP2_UIMM;
        w.wb_sel = WB_ALU;
        w.rf_en  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      w         = '0;
      w.illegal = 1'b1;
    end
  end

  assign ctl = w;

endmodule

// File: rtl/control_pipe.sv
// ID-stage control unit: registers the decoded word under valid/ready, handles
// flush, and stalls issue while the unpipelined mul/div unit is busy.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int unsigned ALU_FUN_W = 6,
  parameter int unsigned EN_M      = 1,
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_LAT   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr_i,
  input  logic                 instr_vld_i,
  output logic                 instr_rdy_o,
  input  logic                 flush_i,
  input  logic                 ex_rdy_i,
  output logic                 ctl_vld_o,
  output logic [1:0]           pc_sel_o,
  output logic [1:0]           op1sel_o,
  output logic [1:0]           op2sel_o,
  output logic [1:0]           wb_sel_o,
  output logic                 mem_wr_o,
  output logic                 mem_rd_o,
  output logic [2:0]           mem_size_o,
  output logic                 rf_en_o,
  output logic                 md_op_o,
  output logic [ALU_FUN_W-1:0] alu_fun_o,
  output logic                 illegal_o,
  output logic                 md_busy_o
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CTL_W-1:0] dec_bits;
  ctl_word_t        dec_w;
  logic             dec_is_div;
  ctl_word_t        ctl_q;
  logic             ctl_vld_q;
  logic             accept;
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  control_decode #(.EN_M(EN_M)) u_decode (
    .instr     (instr_i),
    .ctl       (dec_bits),
    .md_is_div (dec_is_div)
  );

  assign dec_w = ctl_word_t'(dec_bits);

  assign instr_rdy_o = !reset && !flush_i && (state_q == ST_IDLE) && (!ctl_vld_q || ex_rdy_i);
  assign accept      = instr_vld_i && instr_rdy_o;

  // flush drops only the valid bit; stale fields are never observed with ctl_vld_o low
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q     <= '0;
      ctl_vld_q <= 1'b0;
    end else if (flush_i) begin
      ctl_vld_q <= 1'b0;
    end else if (accept) begin
      ctl_q     <= dec_w;
      ctl_vld_q <= 1'b1;
    end else if (ex_rdy_i) begin
      ctl_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && dec_w.md_op) begin
          state_d = ST_MD_BUSY;
          cnt_d   = dec_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end
      end
      ST_MD_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ctl_vld_o  = ctl_vld_q;
  assign pc_sel_o   = ctl_q.pc_sel;
  assign op1sel_o   = ctl_q.op1sel;
  assign op2sel_o   = ctl_q.op2sel;
  assign wb_sel_o   = ctl_q.wb_sel;
  assign mem_wr_o   = ctl_q.mem_wr;
  assign mem_rd_o   = ctl_q.mem_rd;
  assign mem_size_o = ctl_q.mem_size;
  assign rf_en_o    = ctl_q.rf_en;
  assign md_op_o    = ctl_q.md_op;
  assign alu_fun_o  = ALU_FUN_W'(ctl_q.alu_fun);
  assign illegal_o  = ctl_q.illegal;
  assign md_busy_o  = (cnt_q != '0);

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: instruction-pattern reference model, random
// handshake/flush traffic, and an EN_M=0 instance for the illegal M-op case.
module tb_control_pipe;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 32;

  localparam logic [5:0] A_ADD = 6'b000000, A_SUB = 6'b000001, A_SLL = 6'b000010;
  localparam logic [5:0] A_SRL = 6'b000100, A_SRA = 6'b000110, A_OR = 6'b001000;
  localparam logic [5:0] A_AND = 6'b010000, A_XOR = 6'b100000, A_SLT = 6'b101001;
  localparam logic [5:0] A_SLTU = 6'b110001;

  localparam int C_ILL = -1, C_R = 0, C_M = 1, C_I = 2, C_LD = 3, C_ST = 4;
  localparam int C_BR = 5, C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr_i = '0;
  logic        instr_vld_i = 1'b0, flush_i = 1'b0, ex_rdy_i = 1'b0;
  logic        instr_rdy_o, ctl_vld_o, mem_wr_o, mem_rd_o, rf_en_o, md_op_o, illegal_o, md_busy_o;
  logic [1:0]  pc_sel_o, op1sel_o, op2sel_o, wb_sel_o;
  logic [2:0]  mem_size_o;
  logic [5:0]  alu_fun_o;
  logic [21:0] dut_word;

  logic [31:0] n_instr = '0;
  logic        n_vld = 1'b0;
  logic        n_rdy, n_ctl_vld, n_mem_wr, n_mem_rd, n_rf_en, n_md_op, n_illegal, n_busy;
  logic [1:0]  n_pc_sel, n_op1sel, n_op2sel, n_wb_sel;
  logic [2:0]  n_mem_size;
  logic [5:0]  n_alu_fun;
  logic [21:0] n_word;

  control_pipe #(.ALU_FUN_W(6), .EN_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .instr_vld_i(instr_vld_i),
    .instr_rdy_o(instr_rdy_o), .flush_i(flush_i), .ex_rdy_i(ex_rdy_i),
    .ctl_vld_o(ctl_vld_o), .pc_sel_o(pc_sel_o), .op1sel_o(op1sel_o), .op2sel_o(op2sel_o),
    .wb_sel_o(wb_sel_o), .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_size_o(mem_size_o),
    .rf_en_o(rf_en_o), .md_op_o(md_op_o), .alu_fun_o(alu_fun_o), .illegal_o(illegal_o),
    .md_busy_o(md_busy_o)
  );

  control_pipe #(.ALU_FUN_W(6), .EN_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_nom (
    .clk(clk), .reset(reset), .instr_i(n_instr), .instr_vld_i(n_vld),
    .instr_rdy_o(n_rdy), .flush_i(1'b0), .ex_rdy_i(1'b1),
    .ctl_vld_o(n_ctl_vld), .pc_sel_o(n_pc_sel), .op1sel_o(n_op1sel), .op2sel_o(n_op2sel),
    .wb_sel_o(n_wb_sel), .mem_wr_o(n_mem_wr), .mem_rd_o(n_mem_rd), .mem_size_o(n_mem_size),
    .rf_en_o(n_rf_en), .md_op_o(n_md_op), .alu_fun_o(n_alu_fun), .illegal_o(n_illegal),
    .md_busy_o(n_busy)
  );

  assign dut_word = {pc_sel_o, op1sel_o, op2sel_o, wb_sel_o, mem_wr_o, mem_rd_o,
                     mem_size_o, rf_en_o, md_op_o, alu_fun_o, illegal_o};
  assign n_word   = {n_pc_sel, n_op1sel, n_op2sel, n_wb_sel, n_mem_wr, n_mem_rd,
                     n_mem_size, n_rf_en, n_md_op, n_alu_fun, n_illegal};

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Instruction patterns: (instr & mask) == match identifies the mnemonic
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          cls;
    logic [5:0]  alu;
  } ent_t;
  ent_t tbl[$];

  function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                              input int cls, input logic [5:0] alu);
    ent_t e;
    e.mask = mask; e.match = match; e.cls = cls; e.alu = alu;
    tbl.push_back(e);
  endfunction

  task automatic build_table();
    logic [31:0] rm, im;
    rm = 32'hFE00707F;
    im = 32'h0000707F;
    add(rm, 32'h00000033, C_R, A_ADD);  add(rm, 32'h40000033, C_R, A_SUB);
    add(rm, 32'h00001033, C_R, A_SLL);  add(rm, 32'h00002033, C_R, A_SLT);
    add(rm, 32'h00003033, C_R, A_SLTU); add(rm, 32'h00004033, C_R, A_XOR);
    add(rm, 32'h00005033, C_R, A_SRL);  add(rm, 32'h40005033, C_R, A_SRA);
    add(rm, 32'h00006033, C_R, A_OR);   add(rm, 32'h00007033, C_R, A_AND);
    for (int f = 0; f < 8; f++) add(rm, 32'h02000033 | (f << 12), C_M, A_ADD);
    add(im, 32'h00000013, C_I, A_ADD);  add(im, 32'h00002013, C_I, A_SLT);
    add(im, 32'h00003013, C_I, A_SLTU); add(im, 32'h00004013, C_I, A_XOR);
    add(im, 32'h00006013, C_I, A_OR);   add(im, 32'h00007013, C_I, A_AND);
    add(rm, 32'h00001013, C_I, A_SLL);  add(rm, 32'h00005013, C_I, A_SRL);
    add(rm, 32'h40005013, C_I, A_SRA);
    foreach (tbl[k]) if (k < 0) tbl[k].alu = A_ADD;
    add(im, 32'h00000003, C_LD, A_ADD); add(im, 32'h00001003, C_LD, A_ADD);
    add(im, 32'h00002003, C_LD, A_ADD); add(im, 32'h00004003, C_LD, A_ADD);
    add(im, 32'h00005003, C_LD, A_ADD);
    add(im, 32'h00000023, C_ST, A_ADD); add(im, 32'h00001023, C_ST, A_ADD);
    add(im, 32'h00002023, C_ST, A_ADD);
    add(im, 32'h00000063, C_BR, A_SUB); add(im, 32'h00001063, C_BR, A_SUB);
    add(im, 32'h00004063, C_BR, A_SLT); add(im, 32'h00005063, C_BR, A_SLT);
    add(im, 32'h00006063, C_BR, A_SLTU); add(im, 32'h00007063, C_BR, A_SLTU);
    add(32'h7F, 32'h6F, C_JAL, A_ADD);  add(im, 32'h00000067, C_JALR, A_ADD);
    add(32'h7F, 32'h37, C_LUI, A_ADD);  add(32'h7F, 32'h17, C_AUIPC, A_ADD);
  endtask

  function automatic int classify(input logic [31:0] ins, input bit en_m, output logic [5:0] alu);
    int cls = C_ILL;
    alu = A_ADD;
    foreach (tbl[k]) if ((ins & tbl[k].mask) == tbl[k].match) begin
      cls = tbl[k].cls;
      alu = tbl[k].alu;
    end
    if (cls == C_M) begin
      if (en_m) alu = {3'b000, ins[14:12]};
      else begin cls = C_ILL; alu = A_ADD; end
    end
    return cls;
  endfunction

  function automatic logic [21:0] ref_word(input logic [31:0] ins, input bit en_m);
    logic [1:0] pc, o1, o2, wb;
    logic       mw, mr, rf, md, ill;
    logic [2:0] sz;
    logic [5:0] alu;
    int         cls;
    cls = classify(ins, en_m, alu);
    {pc, o1, o2, wb, mw, mr, sz, rf, md, ill} = '0;
    case (cls)
      C_R:     begin wb = 2'b01; rf = 1; end
      C_M:     begin wb = 2'b11; rf = 1; md = 1; end
      C_I:     begin o2 = 2'b01; wb = 2'b01; rf = 1; end
      C_LD:    begin o2 = 2'b01; mr = 1; rf = 1; sz = ins[14:12]; end
      C_ST:    begin o2 = 2'b11; mw = 1; sz = ins[14:12]; end
      C_BR:    pc = 2'b01;
      C_JAL:   begin pc = 2'b11; wb = 2'b10; rf = 1; end
      C_JALR:  begin pc = 2'b10; o2 = 2'b01; wb = 2'b10; rf = 1; end
      C_LUI:   begin o1 = 2'b10; o2 = 2'b10; wb = 2'b01; rf = 1; end
      C_AUIPC: begin o1 = 2'b01; o2 = 2'b10; wb = 2'b01; rf = 1; end
      default: begin ill = 1; alu = '0; end
    endcase
    return {pc, o1, o2, wb, mw, mr, sz, rf, md, alu, ill};
  endfunction

  function automatic int ref_lat(input logic [31:0] ins);
    logic [5:0] alu;
    if (classify(ins, 1'b1, alu) != C_M) return 0;
    return ins[14] ? DIV_LAT : MUL_LAT;
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    if ($urandom_range(0, 9) == 0) return $urandom;
    k = $urandom_range(0, tbl.size() - 1);
    return tbl[k].match | ($urandom & ~tbl[k].mask);
  endfunction

  // Reference state: held word valid, remaining busy cycles, expected words in flight
  logic        m_vld = 1'b0;
  int          m_busy = 0;
  logic [21:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset && ctl_vld_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL ctl_word: got %h expected no valid word (t=%0t)", dut_word, $time);
      end else begin
        check("ctl_word", dut_word, exp_q[0]);
        if (ex_rdy_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input logic vld, input logic [31:0] ins, input logic exr, input logic fl);
    logic rdy_p, acc;
    @(posedge clk); #1;
    instr_vld_i = vld; instr_i = ins; flush_i = fl; ex_rdy_i = fl ? 1'b0 : exr;
    rdy_p = !fl && (m_busy == 0) && (!m_vld || ex_rdy_i);
    acc   = vld && rdy_p;
    #1;
    check("instr_rdy", instr_rdy_o, rdy_p);
    check("ctl_vld", ctl_vld_o, m_vld);
    check("md_busy", md_busy_o, m_busy != 0);
    @(negedge clk); #1;
    if (fl) begin
      if (m_vld) void'(exp_q.pop_front());
      m_vld = 1'b0;
    end else if (acc) begin
      exp_q.push_back(ref_word(ins, 1'b1));
      m_vld = 1'b1;
    end else if (ex_rdy_i) begin
      m_vld = 1'b0;
    end
    if (acc && ref_lat(ins) != 0) m_busy = ref_lat(ins);
    else if (m_busy > 0) m_busy--;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1; instr_vld_i = 1'b0; flush_i = 1'b0; ex_rdy_i = 1'b0; n_vld = 1'b0;
    repeat (n) begin
      #1 check("rdy_in_reset", instr_rdy_o, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_vld = 1'b0; m_busy = 0; exp_q.delete();
    #1;
    check("reset_outputs", {dut_word, ctl_vld_o, md_busy_o}, 0);
    check("rdy_after_reset", instr_rdy_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    build_table();
    do_reset(3);

    cycle(1, 32'h002081B3, 1, 0);
    cycle(1, 32'h402081B3, 1, 0);
    cycle(1, 32'hFFFFFFFF, 1, 0);
    cycle(0, 32'h0, 1, 0);

    cycle(1, 32'h000080E7, 0, 0);
    repeat (4) cycle(1, 32'h002081B3, 0, 0);
    cycle(0, 32'h0, 1, 0);

    cycle(1, 32'h0220C1B3, 1, 0);
    repeat (35) cycle(1, 32'h002081B3, 1, 0);
    cycle(0, 32'h0, 1, 0);

    cycle(1, 32'h000080E7, 0, 0);
    cycle(1, 32'h002081B3, 1, 1);
    cycle(0, 32'h0, 1, 0);
    cycle(1, 32'h0220C1B3, 0, 0);
    cycle(1, 32'h002081B3, 0, 1);
    repeat (5) cycle(0, 32'h0, 0, 0);
    do_reset(2);

    @(posedge clk); #1;
    n_vld = 1'b1; n_instr = 32'h0220C1B3;
    @(posedge clk); #1;
    n_vld = 1'b0;
    #1;
    check("nom_ctl_vld", n_ctl_vld, 1);
    check("nom_word", n_word, ref_word(32'h0220C1B3, 1'b0));
    check("nom_busy", n_busy, 0);
    @(posedge clk); #2;
    check("nom_busy_later", n_busy, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1);
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end
    repeat (3) cycle(0, 32'h0, 1, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
